// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Request/grant/completion bundle between the I/D caches, the
//               AXI4-Lite master and mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
   logic i_req_read_i;
   logic i_req_read_d;
   logic i_req_write_d;
   logic i_axi_done;
   logic o_axi_read_start;
   logic o_axi_write_start;
   logic o_sel_i;
   logic o_done_i;
   logic o_done_d;
   logic o_busy;
   logic o_timeout;

   // Arbiter side
   modport slave (
      input  i_req_read_i, i_req_read_d, i_req_write_d, i_axi_done,
      output o_axi_read_start, o_axi_write_start, o_sel_i,
             o_done_i, o_done_d, o_busy, o_timeout
   );

   // Requester / bus side
   modport master (
      output i_req_read_i, i_req_read_d, i_req_write_d, i_axi_done,
      input  o_axi_read_start, o_axi_write_start, o_sel_i,
             o_done_i, o_done_d, o_busy, o_timeout
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Single-owner arbiter for I-cache refill, D-cache refill and
//               D-cache write-back onto one AXI4-Lite master, with watchdog.
//               Macro MEM_ARB_ROUND_ROBIN_EN selects round-robin read
//               arbitration; otherwise the D-cache wins read contention.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic         i_clk,
   input  logic         i_arst,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_I  = 2'd1,
      GNT_DR = 2'd2,
      GNT_DW = 2'd3
   } state_t;

   localparam logic [15:0] c_CNT_MAX  = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] c_CNT_TRIP = 16'(TIMEOUT_CYCLES - 2);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_cnt;
   logic        r_timeout;
   logic        w_read_pick_i;
   logic        w_read_start;
   logic        w_write_start;
   logic        w_sel_i;
   logic        w_done_i;
   logic        w_done_d;
   logic        w_busy;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Remembers which reader held the last read grant; reset favours I next.
   logic r_last_i;

   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         r_last_i <= 1'b0;
      end else if (r_state == IDLE && w_next == GNT_I) begin
         r_last_i <= 1'b1;
      end else if (r_state == IDLE && w_next == GNT_DR) begin
         r_last_i <= 1'b0;
      end
   end

   assign w_read_pick_i = ~r_last_i;
`else
   assign w_read_pick_i = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_next;
         // Grants are only entered from IDLE, so clearing here clears on entry.
         if (r_state == IDLE) begin
            r_cnt <= '0;
         end else if (!bus.i_axi_done && r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 16'd1;
         end
         if (r_state != IDLE && !bus.i_axi_done && r_cnt == c_CNT_TRIP) begin
            r_timeout <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next        = r_state;
      w_read_start  = 1'b0;
      w_write_start = 1'b0;
      w_sel_i       = 1'b0;
      w_done_i      = 1'b0;
      w_done_d      = 1'b0;
      w_busy        = 1'b1;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (bus.i_req_write_d) begin
               w_next = GNT_DW;
            end else if (bus.i_req_read_i && bus.i_req_read_d) begin
               w_next = w_read_pick_i ? GNT_I : GNT_DR;
            end else if (bus.i_req_read_i) begin
               w_next = GNT_I;
            end else if (bus.i_req_read_d) begin
               w_next = GNT_DR;
            end
         end
         GNT_I: begin
            w_sel_i      = 1'b1;
            w_read_start = ~bus.i_axi_done;
            w_done_i     = bus.i_axi_done;
            if (bus.i_axi_done) w_next = IDLE;
         end
         GNT_DR: begin
            w_read_start = ~bus.i_axi_done;
            w_done_d     = bus.i_axi_done;
            if (bus.i_axi_done) w_next = IDLE;
         end
         GNT_DW: begin
            w_write_start = ~bus.i_axi_done;
            w_done_d      = bus.i_axi_done;
            if (bus.i_axi_done) w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   assign bus.o_axi_read_start  = w_read_start;
   assign bus.o_axi_write_start = w_write_start;
   assign bus.o_sel_i           = w_sel_i;
   assign bus.o_done_i          = w_done_i;
   assign bus.o_done_d          = w_done_d;
   assign bus.o_busy            = w_busy;
   assign bus.o_timeout         = r_timeout;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: watchdog limit, in cycles, for one granted transaction; legal range 2..65535.
REQ-002 i_clk  in  1  clock; all state updates on rising edge.
REQ-003 i_arst  in  1  reset, synchronous, active-high.
REQ-004 i_req_read_i  in  1  I-cache line-fill request, level, held until o_done_i.
REQ-005 i_req_read_d  in  1  D-cache line-fill request, level, held until o_done_d.
REQ-006 i_req_write_d  in  1  D-cache write-back request, level, held until o_done_d.
REQ-007 i_axi_done  in  1  single-cycle completion pulse from AXI4-Lite master.
REQ-008 o_axi_read_start  out  1  read start to AXI master.
REQ-009 o_axi_write_start  out  1  write start to AXI master.
REQ-010 o_sel_i  out  1  address/data mux select: 1 = I-cache owns bus, 0 = D-cache.
REQ-011 o_done_i  out  1  completion pulse routed to I-cache.
REQ-012 o_done_d  out  1  completion pulse routed to D-cache.
REQ-013 o_busy  out  1  high in any non-IDLE state.
REQ-014 o_timeout  out  1  sticky watchdog error flag.

Function
REQ-015 States SHALL be IDLE, GNT_I, GNT_DR, GNT_DW, encoded 2 bits, registered.
REQ-016 IDLE: i_req_write_d SHALL win -> GNT_DW, regardless of other requests.
REQ-017 IDLE, no write-back, single read request: SHALL go to GNT_I or GNT_DR accordingly.
REQ-018 IDLE, both reads: SHALL arbitrate per REQ-032/REQ-033.
REQ-019 IDLE, no request: SHALL remain IDLE; all starts and dones low.
REQ-020 Grant SHALL be registered: start asserts the cycle after the request is sampled in IDLE (1-cycle latency).
REQ-021 GNT_I/GNT_DR: o_axi_read_start = ~i_axi_done; GNT_DW: o_axi_write_start = ~i_axi_done; starts never high in IDLE.
REQ-022 o_sel_i SHALL be 1 only in GNT_I; 0 otherwise.
REQ-023 On i_axi_done in GNT_I: o_done_i high same cycle (combinational), next state IDLE.
REQ-024 On i_axi_done in GNT_DR or GNT_DW: o_done_d high same cycle, next state IDLE.
REQ-025 i_axi_done in IDLE SHALL be ignored; no done output, no state change.
REQ-026 Grant SHALL NOT change while in a GNT_* state even if the owning request drops; only i_axi_done or watchdog exits.
REQ-027 Write-back followed by refill: after GNT_DW completes, a held i_req_read_d SHALL be granted via IDLE (min 1 idle cycle between transactions).
REQ-028 Watchdog counter (16 bits) SHALL clear on entry to a GNT_* state and increment each cycle in it.
REQ-029 Counter reaching TIMEOUT_CYCLES-1 without i_axi_done: o_timeout set (sticky), state stays; counter saturates.
REQ-030 i_axi_done on the same cycle the counter reaches the limit SHALL count as completion; o_timeout not set.

Reset
REQ-031 i_arst high at a rising edge SHALL force IDLE, clear counter, clear o_timeout, set last-grant pointer to D, from any state including mid-transaction; all outputs low the following cycle.

Configuration
REQ-032 Macro MEM_ARB_ROUND_ROBIN_EN defined: read contention SHALL grant the source not granted last; 1-bit last-grant pointer updates on each read grant (write-back does not update it); after reset I-cache wins first.
REQ-033 Macro undefined: read contention SHALL always grant the D-cache (fixed priority); no pointer register exists.

Verification
REQ-034 Reset, then i_req_read_i=1 at cycle 0 -> o_axi_read_start=1, o_sel_i=1 at cycle 1; i_axi_done at cycle 5 -> o_done_i=1 at cycle 5, o_busy=0 at cycle 6.
REQ-035 i_req_write_d=1, i_req_read_d=1, i_req_read_i=1 together -> GNT_DW first (o_axi_write_start); after done, read grant per macro; o_done_d only on D transactions.
REQ-036 Both reads held continuously, 4 transactions, done 3 cycles after each start -> with macro grants I,D,I,D; without macro D,D,D,D.
REQ-037 TIMEOUT_CYCLES=8, grant with no i_axi_done -> o_timeout=1 after 7 grant cycles, stays 1, state held; later i_axi_done -> done pulse, IDLE, o_timeout still 1.
REQ-038 i_arst asserted mid-GNT_DR, then i_axi_done next cycle -> all outputs low, no o_done_d, state IDLE, o_timeout 0.
REQ-039 Stray i_axi_done in IDLE with no requests -> no done output, o_busy stays 0.
